spi_responder: RTL
==================

Name: spi_responder

Overview:
- SPI mode-0 responder (target) that lets an external host write to and read back the display byte store over SPI.
- Sits beside the display register file and drives the same load/addr/data write bus the flash-reading SPI initiator drives.
- Exposes a read port into that store.
- All SPI pins are oversampled in the single system clock domain; no logic is clocked by sclk.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on sclk, cs_n and mosi.
- CMD_WRITE, 8'h02, opcode for the write command.
- CMD_READ, 8'h03, opcode for the read command.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- sclk  in  1  host SPI clock; idles low (mode 0).
- cs_n  in  1  host chip select, active-low.
- mosi  in  1  host-to-responder data, MSB first.
- miso  out  1  responder-to-host data, MSB first.
- miso_oe  out  1  miso tri-state enable.
- load  out  1  one-cycle write strobe.
- addr  out  8  write address.
- data  out  8  write data.
- rd_addr  out  8  read-port address.
- rd_data  in  8  read-port data; combinational from rd_addr, valid within 1 clk.
- busy  out  1  high while a transaction is in progress (cs_n low after synchronisation).

Behaviour:
- Reset values: load=0, addr=0, data=0, rd_addr=0, miso=0, miso_oe=0, busy=0. FSM goes to IDLE, bit counter 0.
- sclk, cs_n and mosi each pass through SYNC_STAGES flops. mosi uses the same depth as sclk so it stays aligned.
- Synchronised sclk rise = sample edge. Synchronised sclk fall = shift edge.
- Requirement: sclk period ≥ 8 clk periods, high and low phases each ≥ 4 clk.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
- IDLE -> CMD when synchronised cs_n falls. Bit counter cleared, busy=1, miso_oe=1, miso=0.
- Bytes assemble MSB first. A byte is complete on the 8th sample edge.
- CMD complete:
  - CMD_WRITE -> ADDR (write).
  - CMD_READ -> ADDR (read).
  - Any other opcode -> IGNORE; miso held 0 until cs_n rises.
- ADDR complete:
  - Write: addr register := byte, then -> WDATA.
  - Read: rd_addr := byte, then -> RDATA. The shift register loads rd_data on the next shift edge, and that same edge drives its MSB onto miso.
- WDATA, each complete byte:
  - data := byte.
  - load=1 for exactly one clk, in the cycle after the completing sample edge is detected; addr is stable during that cycle.
  - addr increments in the cycle after load.
  - Unlimited bytes per transaction.
- RDATA:
  - miso changes only on shift edges.
  - On the 8th sample edge of each byte, rd_addr increments.
  - On the following shift edge the shift register reloads from rd_data (which has settled by then) and drives the new MSB.
- Address wrap: addr and rd_addr wrap 8'hFF -> 8'h00 with no flag.
- cs_n rising (synchronised) in any state:
  - Return to IDLE on the next clk; busy=0, miso_oe=0, miso=0.
  - A partial byte is discarded; no load is issued for it.
  - addr and rd_addr keep their last values.
- Same-cycle cs_n rise and byte completion: cs_n wins; no load.
- Reset mid-transaction: immediate return to reset values. The next transaction begins only after cs_n is seen high then low.
- cs_n already low when rst deasserts: treated as not-started; remain IDLE until a rise then fall.

Optional Feature:
- Macro: SPI_RESPONDER_STATUS_EN.
- Defined: opcode 8'h05 is accepted in CMD and moves to a STATUS state. With no address phase, the responder repeatedly shifts out an 8-bit write counter. The counter increments on every load, wraps at 255, resets to 0 on rst, and is sampled at each byte boundary.
- Undefined: 8'h05 is an unknown opcode and goes to IGNORE; no counter logic exists.

Decomposition:
- Shared package spi_responder_pkg holds:
  - state enum type (IDLE, CMD, ADDR, WDATA, RDATA, IGNORE, STATUS);
  - localparams CMD_STATUS=8'h05 and BYTE_BITS=8;
  - a typedef for the 8-bit byte.
- One sub-module, pin_sync: parameterised-depth synchroniser plus rise/fall edge detector, instantiated for sclk and cs_n; mosi uses only its synchroniser path.

Test Plan:
- Write burst: cs_n low, bytes 02 05 A1 B2, cs_n high -> load pulses twice, each one clk wide; (addr,data) = (05,A1) then (06,B2); busy falls after cs_n rises.
- Read burst: rd_data model = ~rd_addr; send 03 FE then 16 dummy clocks -> miso returns 01 then 00; rd_addr sequence FE, FF, 00 (wrap).
- Abort: 02 10 then 5 bits, cs_n high -> no load; addr=10; next transaction 02 20 55 writes (20,55).
- Unknown opcode: 7E then 8 clocks -> miso=0 throughout, no load, FSM IDLE after cs_n rises.
- Reset mid-write: rst pulsed during 3rd data bit -> all outputs at reset values immediately; a subsequent 02 00 AA yields load with (00,AA).
- With SPI_RESPONDER_STATUS_EN: three write bytes, then a 05 transaction -> miso returns 03; without the macro, the same 05 transaction returns 00.

Source files
------------

// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI mode-0 responder.
// The STATUS state only becomes reachable with SPI_RESPONDER_STATUS_EN defined.
package spi_responder_pkg;

  typedef logic [7:0] byte_t;

  localparam int unsigned BYTE_BITS  = 8;
  localparam byte_t       CMD_STATUS = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE,
    STATUS
  } state_e;

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchroniser for a group of pins, with rise/fall detection on bit 0.
// Extra bits ride the same chain so they stay aligned with the bit-0 edges.
module pin_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic             prev_q;

  // Resetting to 0 means a pin already low at reset release never shows a fall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1][0];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1][0] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1][0] &  prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 target giving a host write/read access to the display byte store.
// Define SPI_RESPONDER_STATUS_EN to add the write-counter status command.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter byte_t       CMD_WRITE   = 8'h02,
  parameter byte_t       CMD_READ    = 8'h03
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       load,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic [1:0] sm_s;
  logic       mosi_s, cs_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic       unused_sync;

  pin_sync #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sclk_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    ({mosi, sclk}),
    .q_o    (sm_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  pin_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_cs_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (cs_n),
    .q_o    (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  assign mosi_s      = sm_s[1];
  assign unused_sync = ^{sm_s[0], cs_s};

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  byte_t      rx_q, tx_q, addr_q, data_q, rd_addr_q;
  logic       rd_cmd_q, reload_q, load_q, miso_q, miso_oe_q, busy_q;
  byte_t      rx_byte, tx_src;
  logic       byte_done;

  assign rx_byte   = {rx_q[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'(BYTE_BITS - 1));

`ifdef SPI_RESPONDER_STATUS_EN
  byte_t wr_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wr_cnt_q <= '0;
    else if (load_q) wr_cnt_q <= wr_cnt_q + 8'd1;
  end

  assign tx_src = (state_q == STATUS) ? wr_cnt_q : rd_data;
`else
  assign tx_src = rd_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_addr_q <= '0;
      rd_cmd_q  <= 1'b0;
      reload_q  <= 1'b0;
      load_q    <= 1'b0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (load_q) addr_q <= addr_q + 8'd1;
      // cs_n release outranks a byte completing in the same cycle.
      if (cs_rise) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        miso_oe_q <= 1'b0;
        miso_q    <= 1'b0;
        reload_q  <= 1'b0;
      end else if (state_q == IDLE) begin
        if (cs_fall) begin
          state_q   <= CMD;
          bit_cnt_q <= '0;
          rx_q      <= '0;
          busy_q    <= 1'b1;
          miso_oe_q <= 1'b1;
          miso_q    <= 1'b0;
        end
      end else begin
        if (sclk_rise) begin
          rx_q      <= rx_byte;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        if (byte_done) begin
          case (state_q)
            CMD: begin
              if (rx_byte == CMD_WRITE) begin
                state_q  <= ADDR;
                rd_cmd_q <= 1'b0;
              end else if (rx_byte == CMD_READ) begin
                state_q  <= ADDR;
                rd_cmd_q <= 1'b1;
`ifdef SPI_RESPONDER_STATUS_EN
              end else if (rx_byte == CMD_STATUS) begin
                state_q  <= STATUS;
                reload_q <= 1'b1;
`endif
              end else begin
                state_q <= IGNORE;
              end
            end
            ADDR: begin
              if (rd_cmd_q) begin
                rd_addr_q <= rx_byte;
                reload_q  <= 1'b1;
                state_q   <= RDATA;
              end else begin
                addr_q  <= rx_byte;
                state_q <= WDATA;
              end
            end
            WDATA: begin
              data_q <= rx_byte;
              load_q <= 1'b1;
            end
            RDATA: begin
              rd_addr_q <= rd_addr_q + 8'd1;
              reload_q  <= 1'b1;
            end
            STATUS:  reload_q <= 1'b1;
            default: ;
          endcase
        end
        // The reload waits for the shift edge so rd_data has settled on the new rd_addr.
        if (sclk_fall && (state_q == RDATA || state_q == STATUS)) begin
          if (reload_q) begin
            miso_q   <= tx_src[7];
            tx_q     <= {tx_src[6:0], 1'b0};
            reload_q <= 1'b0;
          end else begin
            miso_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign miso    = miso_q;
  assign miso_oe = miso_oe_q;
  assign load    = load_q;
  assign addr    = addr_q;
  assign data    = data_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;

endmodule
